// File: rtl/riscv_soc.sv
// riscv_soc: minimal single-cycle RV32I system-on-chip.
//   rom_1            : combinational instruction ROM, loaded externally, no reset
//   top_1            : single-cycle RV32I core
//   top_1.reg_file_1 : 32 x 32-bit register file, x0 hardwired to zero
//   dram_1           : word-addressed data RAM, only when RISCV_SOC_DRAM_EN is defined
// Configuration macro: RISCV_SOC_DRAM_EN (enables the data RAM and LW/SW).
// Reset is asynchronous and active-low on the port named 'reset'.

// Instruction ROM. There is no write port: the image is placed in rom_mem
// from outside the design, and fetch is a purely combinational lookup.
module riscv_rom #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);

  logic [31:0] rom_mem [0:DEPTH-1];

  assign data = rom_mem[addr];

endmodule

// Register file with two combinational read ports and one write port.
module riscv_reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [0:31];

  // Clear every register on reset; commit one write per edge, never to x0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

`ifdef RISCV_SOC_DRAM_EN
// Data RAM: combinational read, write on the rising edge, no reset.
module riscv_dram #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          we,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:DEPTH-1];

  // Store the word addressed by the current instruction
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule
`endif

// Single-cycle RV32I core: decode, execute and writeback all happen in the
// cycle the instruction is presented; the edge commits pc, rd and the store.
module riscv_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic [31:0] pc
`ifdef RISCV_SOC_DRAM_EN
  ,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we,
  input  logic [31:0] dmem_rdata
`endif
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
`ifdef RISCV_SOC_DRAM_EN
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
`endif

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]  opcode;
  logic [4:0]  rd_addr;
  logic [2:0]  funct3;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [6:0]  funct7;
  logic [4:0]  shamt;

  logic [31:0] imm_i;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] wb_data;
  logic        wb_en;
  logic        branch_taken;

  assign opcode   = instr[6:0];
  assign rd_addr  = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign funct7   = instr[31:25];
  assign shamt    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign pc_plus4 = pc + 32'd4;

  riscv_reg_file reg_file_1 (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val),
    .we     (wb_en),
    .waddr  (rd_addr),
    .wdata  (wb_data)
  );

  // Branch condition; the two undefined funct3 codes never branch
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = (rs1_val == rs2_val);
      3'b001:  branch_taken = (rs1_val != rs2_val);
      3'b100:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  branch_taken = (rs1_val <  rs2_val);
      3'b111:  branch_taken = (rs1_val >= rs2_val);
      default: branch_taken = 1'b0;
    endcase
  end

`ifdef RISCV_SOC_DRAM_EN
  logic [31:0] imm_s;
  logic        store_en;

  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
`endif

  // Decode and execute: anything not recognised falls through as a NOP
  always_comb begin
    next_pc = pc_plus4;
    wb_en   = 1'b0;
    wb_data = '0;
`ifdef RISCV_SOC_DRAM_EN
    store_en = 1'b0;
`endif
    case (opcode)
      OPC_LUI: begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end
      OPC_AUIPC: begin
        wb_en   = 1'b1;
        wb_data = pc + imm_u;
      end
      OPC_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        next_pc = pc + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          wb_en   = 1'b1;
          wb_data = pc_plus4;
          next_pc = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OPC_BRANCH: begin
        if (branch_taken) begin
          next_pc = pc + imm_b;
        end
      end
      OPC_OP_IMM: begin
        wb_en = 1'b1;
        case (funct3)
          3'b000: wb_data = rs1_val + imm_i;
          3'b010: wb_data = {31'b0, ($signed(rs1_val) < $signed(imm_i))};
          3'b011: wb_data = {31'b0, (rs1_val < imm_i)};
          3'b100: wb_data = rs1_val ^ imm_i;
          3'b110: wb_data = rs1_val | imm_i;
          3'b111: wb_data = rs1_val & imm_i;
          3'b001: begin
            if (funct7 == F7_BASE) wb_data = rs1_val << shamt;
            else                   wb_en   = 1'b0;
          end
          default: begin
            if (funct7 == F7_BASE)     wb_data = rs1_val >> shamt;
            else if (funct7 == F7_ALT) wb_data = $unsigned($signed(rs1_val) >>> shamt);
            else                       wb_en   = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        wb_en = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: wb_data = rs1_val + rs2_val;
          {F7_ALT,  3'b000}: wb_data = rs1_val - rs2_val;
          {F7_BASE, 3'b001}: wb_data = rs1_val << rs2_val[4:0];
          {F7_BASE, 3'b010}: wb_data = {31'b0, ($signed(rs1_val) < $signed(rs2_val))};
          {F7_BASE, 3'b011}: wb_data = {31'b0, (rs1_val < rs2_val)};
          {F7_BASE, 3'b100}: wb_data = rs1_val ^ rs2_val;
          {F7_BASE, 3'b101}: wb_data = rs1_val >> rs2_val[4:0];
          {F7_ALT,  3'b101}: wb_data = $unsigned($signed(rs1_val) >>> rs2_val[4:0]);
          {F7_BASE, 3'b110}: wb_data = rs1_val | rs2_val;
          {F7_BASE, 3'b111}: wb_data = rs1_val & rs2_val;
          default:           wb_en   = 1'b0;
        endcase
      end
`ifdef RISCV_SOC_DRAM_EN
      OPC_LOAD: begin
        if (funct3 == 3'b010) begin
          wb_en   = 1'b1;
          wb_data = dmem_rdata;
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b010) begin
          store_en = 1'b1;
        end
      end
`endif
      default: begin
        wb_en = 1'b0;
      end
    endcase
  end

`ifdef RISCV_SOC_DRAM_EN
  // Stores are blocked while reset is held so the RAM is left untouched
  assign dmem_addr  = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign dmem_wdata = rs2_val;
  assign dmem_we    = store_en & reset;
`endif

  // Program counter: one instruction retired per rising edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

endmodule

// SoC top: ties the core to its ROM and, optionally, the data RAM.
module riscv_soc #(
  parameter int          ROM_DEPTH  = 256,
  parameter int          DRAM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic reset
);

  localparam int ROM_AW = $clog2(ROM_DEPTH);

  logic [31:0] pc;
  logic [31:0] instr;
  logic        unused_pc_bits;

  riscv_rom #(
    .DEPTH (ROM_DEPTH)
  ) rom_1 (
    .addr (pc[ROM_AW+1:2]),
    .data (instr)
  );

  // Fetch ignores the byte offset and the bits above the ROM size
  assign unused_pc_bits = &{1'b0, pc[31:ROM_AW+2], pc[1:0]};

`ifdef RISCV_SOC_DRAM_EN
  localparam int DRAM_AW = $clog2(DRAM_DEPTH);

  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_we;
  logic        unused_dmem_bits;

  riscv_core #(
    .RESET_PC (RESET_PC)
  ) top_1 (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .pc         (pc),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata)
  );

  riscv_dram #(
    .DEPTH (DRAM_DEPTH)
  ) dram_1 (
    .clk   (clk),
    .addr  (dmem_addr[DRAM_AW+1:2]),
    .wdata (dmem_wdata),
    .we    (dmem_we),
    .rdata (dmem_rdata)
  );

  // Data addresses wrap modulo the RAM size, like fetch
  assign unused_dmem_bits = &{1'b0, dmem_addr[31:DRAM_AW+2], dmem_addr[1:0]};
`else
  logic [31:0] unused_dram_depth;

  riscv_core #(
    .RESET_PC (RESET_PC)
  ) top_1 (
    .clk   (clk),
    .reset (reset),
    .instr (instr),
    .pc    (pc)
  );

  assign unused_dram_depth = DRAM_DEPTH;
`endif

endmodule

// File: tb/tb_riscv_soc.sv
// tb_riscv_soc: directed programs loaded into rom_1.rom_mem, results read
// from top_1.reg_file_1.regs and checked against hand-computed values.
// Honours RISCV_SOC_DRAM_EN for the load/store expectations.
module tb_riscv_soc;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

`ifdef RISCV_SOC_DRAM_EN
  localparam logic [31:0] LD_EXP = 32'h0000_05A5;
`else
  localparam logic [31:0] LD_EXP = 32'h0000_0000;
`endif

  riscv_soc dut (
    .clk   (clk),
    .reset (reset)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] get_reg(input int idx);
    return dut.top_1.reg_file_1.regs[idx];
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int idx, input logic [31:0] word);
    dut.rom_1.rom_mem[idx] = word;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) begin
      dut.rom_1.rom_mem[i] = 32'h0;
    end
  endtask

  // Assert reset for a cycle, release on a falling edge
  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] riscv_soc directed test start");

    // Program 1: basic ADDI/ADD and reset state
    clear_rom();
    apply_stimulus(0, enc_i(12'd5, 5'd0, 3'b000, 5'd27, OP_IMM));
    apply_stimulus(1, enc_i(12'd7, 5'd0, 3'b000, 5'd28, OP_IMM));
    apply_stimulus(2, enc_r(7'h00, 5'd28, 5'd27, 3'b000, 5'd29, OP_REG));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("reset_pc", dut.pc, 32'h0);
    for (int i = 0; i < 32; i++) begin
      check_output($sformatf("reset_x%0d", i), get_reg(i), 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    run(3);
    check_output("p1_x27", get_reg(27), 32'd5);
    check_output("p1_x28", get_reg(28), 32'd7);
    check_output("p1_x29", get_reg(29), 32'd12);
    check_output("p1_pc", dut.pc, 32'd12);
    for (int i = 0; i < 27; i++) begin
      check_output($sformatf("p1_other_x%0d", i), get_reg(i), 32'h0);
    end

    // Program 2: x0 ignores writes
    clear_rom();
    apply_stimulus(0, enc_i(12'd3, 5'd0, 3'b000, 5'd27, OP_IMM));
    apply_stimulus(1, enc_i(12'd9, 5'd0, 3'b000, 5'd0, OP_IMM));
    apply_stimulus(2, enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd27, OP_REG));
    reset_dut();
    run(2);
    check_output("p2_x27_pre", get_reg(27), 32'd3);
    check_output("p2_x0", get_reg(0), 32'd0);
    run(1);
    check_output("p2_x27_post", get_reg(27), 32'd0);

    // Program 3: countdown loop, with a mid-loop reset and rerun
    clear_rom();
    apply_stimulus(0, enc_i(12'd3, 5'd0, 3'b000, 5'd28, OP_IMM));
    apply_stimulus(1, enc_i(12'hFFF, 5'd28, 3'b000, 5'd28, OP_IMM));
    apply_stimulus(2, enc_b(13'h1FFC, 5'd0, 5'd28, 3'b001));
    apply_stimulus(3, enc_i(12'd1, 5'd0, 3'b000, 5'd29, OP_IMM));
    reset_dut();
    run(3);
    check_output("p3_branch_pc", dut.pc, 32'd4);
    run(1);
    check_output("p3_mid_x28", get_reg(28), 32'd1);
    reset = 1'b0;
    #1;
    check_output("p3_async_pc", dut.pc, 32'h0);
    check_output("p3_async_x28", get_reg(28), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_output("p3_hold_pc", dut.pc, 32'h0);
    check_output("p3_hold_x28", get_reg(28), 32'h0);
    reset = 1'b1;
    run(8);
    check_output("p3_x28", get_reg(28), 32'd0);
    check_output("p3_x29", get_reg(29), 32'd1);
    check_output("p3_pc", dut.pc, 32'd16);

    // Program 4: compares, shifts, upper immediates, jumps
    clear_rom();
    apply_stimulus(0,  enc_i(12'd1, 5'd0, 3'b000, 5'd1, OP_IMM));
    apply_stimulus(1,  enc_r(7'h20, 5'd1, 5'd0, 3'b000, 5'd27, OP_REG));
    apply_stimulus(2,  enc_r(7'h00, 5'd27, 5'd0, 3'b011, 5'd28, OP_REG));
    apply_stimulus(3,  enc_r(7'h00, 5'd0, 5'd27, 3'b010, 5'd29, OP_REG));
    apply_stimulus(4,  enc_r(7'h20, 5'd4, 5'd27, 3'b101, 5'd30, OP_IMM));
    apply_stimulus(5,  enc_r(7'h00, 5'd28, 5'd27, 3'b101, 5'd31, OP_IMM));
    apply_stimulus(6,  enc_r(7'h00, 5'd31, 5'd1, 3'b001, 5'd25, OP_IMM));
    apply_stimulus(7,  {20'h12345, 5'd22, 7'b0110111});
    apply_stimulus(8,  {20'h00001, 5'd21, 7'b0010111});
    apply_stimulus(9,  enc_j(21'd8, 5'd20));
    apply_stimulus(10, enc_i(12'd99, 5'd0, 3'b000, 5'd19, OP_IMM));
    apply_stimulus(11, enc_i(12'd57, 5'd0, 3'b000, 5'd18, 7'b1100111));
    apply_stimulus(12, enc_i(12'd77, 5'd0, 3'b000, 5'd19, OP_IMM));
    apply_stimulus(14, enc_r(7'h20, 5'd1, 5'd25, 3'b101, 5'd17, OP_REG));
    apply_stimulus(15, enc_i(12'h0F0, 5'd27, 3'b111, 5'd16, OP_IMM));
    reset_dut();
    run(13);
    check_output("p4_sub", get_reg(27), 32'hFFFF_FFFF);
    check_output("p4_sltu", get_reg(28), 32'd1);
    check_output("p4_slt", get_reg(29), 32'd1);
    check_output("p4_srai", get_reg(30), 32'hFFFF_FFFF);
    check_output("p4_srli", get_reg(31), 32'h0000_000F);
    check_output("p4_slli", get_reg(25), 32'h8000_0000);
    check_output("p4_lui", get_reg(22), 32'h1234_5000);
    check_output("p4_auipc", get_reg(21), 32'h0000_1020);
    check_output("p4_jal_link", get_reg(20), 32'd40);
    check_output("p4_skipped", get_reg(19), 32'd0);
    check_output("p4_jalr_link", get_reg(18), 32'd48);
    check_output("p4_sra", get_reg(17), 32'hC000_0000);
    check_output("p4_andi", get_reg(16), 32'h0000_00F0);
    check_output("p4_pc", dut.pc, 32'd64);

    // Program 5: store then loads (plain, wrapped, unaligned address)
    clear_rom();
    apply_stimulus(0, enc_i(12'h5A5, 5'd0, 3'b000, 5'd27, OP_IMM));
    apply_stimulus(1, {7'd0, 5'd27, 5'd0, 3'b010, 5'd8, 7'b0100011});
    apply_stimulus(2, enc_i(12'd8, 5'd0, 3'b010, 5'd29, 7'b0000011));
    apply_stimulus(3, enc_i(12'h408, 5'd0, 3'b010, 5'd26, 7'b0000011));
    apply_stimulus(4, enc_i(12'd11, 5'd0, 3'b010, 5'd25, 7'b0000011));
    reset_dut();
    run(5);
    check_output("p5_x27", get_reg(27), 32'h0000_05A5);
    check_output("p5_lw", get_reg(29), LD_EXP);
    check_output("p5_lw_wrap", get_reg(26), LD_EXP);
    check_output("p5_lw_lowbits", get_reg(25), LD_EXP);
    check_output("p5_pc", dut.pc, 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/riscv_soc.md
# riscv_soc

Minimal single-cycle RV32I system-on-chip: a 32-bit core (`top_1`) fetching from a preloadable instruction ROM (`rom_1`), with an optional word-addressed data RAM. It is the top level of the SoC simulation and has no functional outputs. Benches observe it hierarchically:

- `rom_1.rom_mem` receives the program image via `$readmemb`.
- `top_1.reg_file_1.regs` exposes the architectural registers.

## Interface
- ROM_DEPTH, 256, instruction ROM size in 32-bit words (power of two).
- DRAM_DEPTH, 256, data RAM size in 32-bit words (power of two).
- RESET_PC, 32'h0000_0000, PC value while reset is asserted and after release.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.

Hierarchy names (fixed; benches depend on them):
- `rom_1.rom_mem[0:ROM_DEPTH-1]` is a 32-bit array.
- `top_1.reg_file_1.regs[0:31]` is a 32-bit array.

## Operation
- Fetch: ROM is read combinationally; instruction = `rom_mem[pc[log2(ROM_DEPTH)+1:2]]`.
  - PC bits [1:0] are ignored.
  - Upper PC bits are ignored, so fetch wraps modulo ROM_DEPTH words.
- ROM has no reset and no write port; contents come only from the bench.
- Supported instructions, executed in one cycle each:
  - LUI, AUIPC.
  - JAL, JALR (target bit 0 cleared).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
  - LW/SW, only when the data RAM is compiled in (see Configuration).
- All other opcodes/funct combinations, including FENCE, ECALL and all-zero words, execute as NOP: PC+4, no writes.
- Arithmetic rules:
  - Arithmetic is 32-bit, wrap-around.
  - Immediates are sign-extended per RV32I format.
  - Shift amount is rs2[4:0] or shamt[4:0].
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
- Register file: 2 combinational read ports, 1 write port.
  - x0 always reads 0; writes to x0 are discarded and `regs[0]` stays 0.
- Next PC:
  - Default is PC+4.
  - Taken branch: PC+B-imm.
  - JAL: PC+J-imm.
  - JALR: (rs1+I-imm)&~1.
  - No misalignment trap.
- Data RAM (when present):
  - Word-addressed by `addr[log2(DRAM_DEPTH)+1:2]`, wrapping the same way as fetch.
  - Combinational read; write on clock edge.
  - Low address bits are ignored.

## Timing
- Reset asserted (reset=0), asynchronously and immediately:
  - pc=RESET_PC.
  - All `regs[i]`=0.
- Data RAM and ROM are not cleared by reset.
- While reset is low, no register, PC or RAM writes occur.
- Reset released: the first rising edge with reset=1 executes the instruction at RESET_PC.
- Each rising edge commits exactly one instruction:
  - PC updates.
  - rd updates.
  - The memory write occurs.
- Results are visible in `regs` immediately after that edge.
- Latency: one cycle per instruction; no stalls, no pipeline hazards.
- An instruction reading a register written by the previous instruction sees the new value.
- Reset asserted mid-program aborts the in-flight instruction; nothing is committed on that edge.

## Configuration
- Macro `RISCV_SOC_DRAM_EN`.
- Defined: data RAM of DRAM_DEPTH words is instantiated, and LW/SW execute as specified.
- Undefined:
  - No data RAM exists.
  - LW and SW decode as NOPs: PC+4, no register write.
  - All other behaviour is unchanged.

## Test plan
- Reset then ADDI x27,x0,5; ADDI x28,x0,7; ADD x29,x27,x28 -> after 3 post-reset edges x27=5, x28=7, x29=12; all other regs 0.
- ADDI x0,x0,9 then ADD x27,x0,x0 -> x0 reads 0 and x27=0.
- Countdown loop: ADDI x28,x0,3; loop: ADDI x28,x28,-1; BNE x28,x0,loop; ADDI x29,x0,1 -> x28 ends 0; x29=1 after 8 edges.
- SUB x27,x0,1 (x1=1) then SLTU x28,x0,x27 and SLT x29,x27,x0 -> x27=32'hFFFFFFFF, x28=1, x29=1.
- With RISCV_SOC_DRAM_EN:
  - SW x27,8(x0) then LW x29,8(x0) -> x29 equals x27.
  - Without the macro, x29 stays 0.
- Pull reset low mid-loop for one cycle:
  - pc returns to RESET_PC and all regs read 0 immediately.
  - After release the program reruns and gives identical results.
